ram_line_buffer_taps: RTL

//  Parametrised RAM-based multi-tap delay line; successor to the single-tap 1-bit shift register.

---
 rtl/ram_line_buffer_taps.sv | 116 +++++++++++
 1 files changed

// File: rtl/ram_line_buffer_taps.sv
// Multi-tap line buffer: one RAM word per column holds NTAPS cascaded samples, shifted in place on each accept.
// Optional macro LB_OUT_REG_EN adds one output register stage (latency 2) on Dout, Valid and Primed.
module ram_line_buffer_taps #(
    parameter int DSIZE  = 8,
    parameter int WDEPTH = 800,
    parameter int NTAPS  = 3,
    parameter int ASIZE  = $clog2(WDEPTH)
) (
    input  logic                   clk,
    input  logic                   Reset_n,
    input  logic                   En,
    input  logic [DSIZE-1:0]       Din,
    input  logic [ASIZE-1:0]       Len,
    output logic [NTAPS*DSIZE-1:0] Dout,
    output logic                   Valid,
    output logic                   Primed
);
    localparam int W  = NTAPS * DSIZE;
    localparam int LW = $clog2(WDEPTH + 1);
    localparam int FW = $clog2(NTAPS * WDEPTH + 1);

    logic [W-1:0]     mem [WDEPTH];
    logic [W-1:0]     rd_word;
    logic [W-1:0]     wr_word;
    logic [W-1:0]     tap_d;
    logic [W-1:0]     dout_q;
    logic [LW-1:0]    len_q;
    logic [LW-1:0]    len_clamped;
    logic [ASIZE-1:0] ptr_q, ptr_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [FW-1:0]    full_lvl;
    logic [NTAPS-1:0] tap_ok;
    logic             valid_q;
    logic             primed_q;

    // A zero or oversized length falls back to the full RAM depth.
    always_comb begin
        len_clamped = LW'(WDEPTH);
        if (Len != '0 && int'(Len) <= WDEPTH) begin
            len_clamped = LW'(Len);
        end
    end

    assign rd_word  = mem[ptr_q];
    assign ptr_d    = (LW'(ptr_q) == len_q - 1'b1) ? '0 : ptr_q + 1'b1;
    assign full_lvl = FW'(NTAPS * int'(len_q));
    assign fill_d   = (fill_q < full_lvl) ? fill_q + 1'b1 : fill_q;

    generate
        if (NTAPS > 1) begin : g_cascade
            assign wr_word = {rd_word[W-DSIZE-1:0], Din};
        end else begin : g_single
            assign wr_word = Din;
        end
    endgenerate

    // Tap k only shows RAM data once k full lines have been written since reset.
    generate
        for (genvar gi = 0; gi < NTAPS; gi++) begin : g_tap
            assign tap_ok[gi] = (fill_q >= FW'((gi + 1) * int'(len_q)));
            assign tap_d[gi*DSIZE +: DSIZE] = tap_ok[gi] ? rd_word[gi*DSIZE +: DSIZE] : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (En && Reset_n) begin
            mem[ptr_q] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            len_q    <= len_clamped;
            ptr_q    <= '0;
            fill_q   <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            valid_q <= En;
            if (En) begin
                ptr_q    <= ptr_d;
                fill_q   <= fill_d;
                dout_q   <= tap_d;
                primed_q <= tap_ok[NTAPS-1];
            end
        end
    end

`ifdef LB_OUT_REG_EN
    logic [W-1:0] dout2_q;
    logic         valid2_q;
    logic         primed2_q;

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            dout2_q   <= '0;
            valid2_q  <= 1'b0;
            primed2_q <= 1'b0;
        end else begin
            dout2_q   <= dout_q;
            valid2_q  <= valid_q;
            primed2_q <= primed_q;
        end
    end

    assign Dout   = dout2_q;
    assign Valid  = valid2_q;
    assign Primed = primed2_q;
`else
    assign Dout   = dout_q;
    assign Valid  = valid_q;
    assign Primed = primed_q;
`endif

endmodule
